// File: rtl/sram_like_arbiter_if.sv
// SRAM-like request/response channel: requester side is master, memory side is slave.
interface sram_like_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  logic              req;
  logic              wr;
  logic [SIZE_W-1:0] size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store channels,
// one transaction in flight, responses steered back to the owning requester.
module sram_like_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master mem
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } fields_t;

  state_t  state;
  state_t  state_nxt;
  logic    owner;       // 0 = inst, 1 = data
  logic    last_grant;
  fields_t lat;

  logic    arb_en;
  logic    grant;
  logic    win_data;
  fields_t win_fields;

  // Arbitration is open when idle, or in the cycle the current response returns
  always_comb begin
    arb_en     = (state == IDLE) || ((state == RESP) && mem.data_ok);
    win_data   = data.req && (!inst.req || DATA_PRIO || !last_grant);
    grant      = arb_en && (inst.req || data.req);
    win_fields = win_data ? {data.wr, data.size, data.addr, data.wdata}
                          : {inst.wr, inst.size, inst.addr, inst.wdata};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      lat        <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner      <= win_data;
        last_grant <= win_data;
        lat        <= win_fields;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = REQ;
      REQ:     if (mem.addr_ok) state_nxt = RESP;
      RESP:    if (mem.data_ok) state_nxt = grant ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshakes are qualified by phase so stray memory strobes never leak out
  always_comb begin
    mem.req       = (state == REQ);
    mem.wr        = lat.wr;
    mem.size      = lat.size;
    mem.addr      = lat.addr;
    mem.wdata     = lat.wdata;
    inst.addr_ok  = (state == REQ)  && mem.addr_ok && !owner;
    data.addr_ok  = (state == REQ)  && mem.addr_ok &&  owner;
    inst.data_ok  = (state == RESP) && mem.data_ok && !owner;
    data.data_ok  = (state == RESP) && mem.data_ok &&  owner;
    inst.rdata    = mem.rdata;
    data.rdata    = mem.rdata;
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: two instances (data priority, round-robin) checked
// every cycle against a transaction-level reference plus directed scenario checks.
module tb_sram_like_arbiter;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        rq_req [2][2];
  txn_t        rq_t   [2][2];
  logic        m_aok  [2];
  logic        m_dok  [2];
  logic [31:0] m_rdata[2];

  logic        o_mreq [2];
  txn_t        o_mt   [2];
  logic        o_aok  [2][2];
  logic        o_dok  [2][2];
  logic [31:0] o_rdata[2][2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    sram_like_arbiter_if ib ();
    sram_like_arbiter_if db ();
    sram_like_arbiter_if mb ();
    assign ib.req = rq_req[k][0];
    assign {ib.wr, ib.size, ib.addr, ib.wdata} = rq_t[k][0];
    assign db.req = rq_req[k][1];
    assign {db.wr, db.size, db.addr, db.wdata} = rq_t[k][1];
    assign mb.addr_ok = m_aok[k];
    assign mb.data_ok = m_dok[k];
    assign mb.rdata   = m_rdata[k];
    assign o_mreq[k]     = mb.req;
    assign o_mt[k]       = {mb.wr, mb.size, mb.addr, mb.wdata};
    assign o_aok[k][0]   = ib.addr_ok;
    assign o_aok[k][1]   = db.addr_ok;
    assign o_dok[k][0]   = ib.data_ok;
    assign o_dok[k][1]   = db.data_ok;
    assign o_rdata[k][0] = ib.rdata;
    assign o_rdata[k][1] = db.rdata;
    sram_like_arbiter #(.DATA_PRIO(k == 0)) u_dut (
      .clk(clk), .resetn(resetn), .inst(ib), .data(db), .mem(mb)
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus state
  txn_t        q [2][2][$];
  int          mode;          // 0 = scripted delays, 1 = manual, 2 = random
  bit          rnd_req;
  int          aok_dly, dok_dly;
  int          acnt [2];
  int          dcnt [2];
  bit          wait_d [2];
  logic [31:0] mem_word;

  // reference: one issued transaction slot per instance
  bit   busy [2];
  bit   acc  [2];
  bit   own  [2];
  bit   lastg[2];
  txn_t lat  [2];

  // observed tallies
  int          c_aok [2][2];
  int          c_dok [2][2];
  int          c_mreq[2];
  logic [31:0] l_rdata[2][2];
  int          glog [2][$];

  function automatic txn_t mk(bit wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wdata);
    txn_t t;
    t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic logic [127:0] log_code(int k);
    logic [127:0] c;
    c = '0;
    for (int i = 0; i < glog[k].size(); i++) c = (c << 4) | 128'(glog[k][i] + 1);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rnd_req && q[k][ch].size() == 0 && $urandom_range(0, 9) < 4)
          q[k][ch].push_back(mk(1'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom));
        else if (rnd_req && q[k][ch].size() != 0 && $urandom_range(0, 19) == 0)
          void'(q[k][ch].pop_front());
        rq_req[k][ch] = (q[k][ch].size() != 0);
        if (q[k][ch].size() != 0) rq_t[k][ch] = q[k][ch][0];
      end
      case (mode)
        0: begin
          if (o_mreq[k]) begin acnt[k]++; m_aok[k] = (acnt[k] > aok_dly); end
          else m_aok[k] = 1'b0;
          m_dok[k] = wait_d[k] && (dcnt[k] >= dok_dly);
          if (wait_d[k]) dcnt[k]++;
          m_rdata[k] = mem_word;
        end
        2: begin
          m_aok[k]   = 1'($urandom);
          m_dok[k]   = ($urandom_range(0, 2) == 0);
          m_rdata[k] = $urandom;
        end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    bit exp_mreq, resp, free, w;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_mreq = busy[k] && !acc[k];
      resp     = busy[k] && acc[k] && m_dok[k];
      chk($sformatf("d%0d.mem_req", k), 128'(o_mreq[k]), 128'(exp_mreq));
      chk($sformatf("d%0d.addr_ok", k), 128'({o_aok[k][1], o_aok[k][0]}),
          128'({exp_mreq && m_aok[k] && own[k], exp_mreq && m_aok[k] && !own[k]}));
      chk($sformatf("d%0d.data_ok", k), 128'({o_dok[k][1], o_dok[k][0]}),
          128'({resp && own[k], resp && !own[k]}));
      if (exp_mreq) chk($sformatf("d%0d.mem_fields", k), 128'(o_mt[k]), 128'(lat[k]));
      if (resp) chk($sformatf("d%0d.rdata", k), 128'({o_rdata[k][1], o_rdata[k][0]}),
                    128'({m_rdata[k], m_rdata[k]}));
      // drivers and tallies react to what the DUT showed
      if (o_mreq[k]) c_mreq[k]++;
      for (int ch = 0; ch < 2; ch++) begin
        if (o_aok[k][ch]) begin
          c_aok[k][ch]++;
          glog[k].push_back(ch);
          if (q[k][ch].size() != 0) void'(q[k][ch].pop_front());
        end
        if (o_dok[k][ch]) begin c_dok[k][ch]++; l_rdata[k][ch] = o_rdata[k][ch]; end
      end
      if (mode == 0) begin
        if (wait_d[k] && m_dok[k]) wait_d[k] = 1'b0;
        if (o_mreq[k] && m_aok[k]) begin wait_d[k] = 1'b1; dcnt[k] = 0; acnt[k] = 0; end
      end
      // advance the reference by the rules of the arbiter
      if (!resetn) begin
        busy[k] = 0; acc[k] = 0; own[k] = 0; lastg[k] = 0; lat[k] = '0;
      end else begin
        free = !busy[k] || resp;
        if (exp_mreq && m_aok[k]) acc[k] = 1;
        if (resp) busy[k] = 0;
        if (free && (rq_req[k][0] || rq_req[k][1])) begin
          w = rq_req[k][1] && (!rq_req[k][0] || (k == 0) || !lastg[k]);
          busy[k] = 1; acc[k] = 0; own[k] = w; lastg[k] = w;
          lat[k] = rq_t[k][int'(w)];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) begin drive(); step(); end
  endtask

  task automatic clear_tally();
    for (int k = 0; k < 2; k++) begin
      glog[k].delete();
      c_mreq[k] = 0;
      for (int ch = 0; ch < 2; ch++) begin
        c_aok[k][ch] = 0; c_dok[k][ch] = 0; l_rdata[k][ch] = '0;
      end
    end
  endtask

  task automatic do_reset();
    mode = 1;
    rnd_req = 0;
    for (int k = 0; k < 2; k++) begin
      m_aok[k] = 0; m_dok[k] = 0; m_rdata[k] = '0;
      acnt[k] = 0; dcnt[k] = 0; wait_d[k] = 0;
      for (int ch = 0; ch < 2; ch++) q[k][ch].delete();
    end
    resetn = 1'b0;
    run(2);
    resetn = 1'b1;
    clear_tally();
  endtask

  task automatic chk_outs_zero(string tag);
    for (int k = 0; k < 2; k++)
      chk($sformatf("%s.d%0d", tag, k),
          128'({o_mreq[k], o_mt[k], o_aok[k][1], o_aok[k][0], o_dok[k][1], o_dok[k][0]}), 128'(0));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_aok[k] = 0; m_dok[k] = 0; m_rdata[k] = '0;
      for (int ch = 0; ch < 2; ch++) begin rq_req[k][ch] = 0; rq_t[k][ch] = '0; end
      busy[k] = 0; acc[k] = 0; own[k] = 0; lastg[k] = 0; lat[k] = '0;
    end
    mode = 1; rnd_req = 0; aok_dly = 0; dok_dly = 0; mem_word = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk_outs_zero("reset_outputs");

    // T1: lone fetch, memory answers one cycle after accepting
    mode = 0; aok_dly = 0; dok_dly = 0; mem_word = 32'h3C1D0001;
    q[0][0].push_back(mk(1'b0, 2'd2, 32'hBFC00000, 32'h0));
    run(6);
    chk("t1.inst_addr_ok_cnt", 128'(c_aok[0][0]), 128'(1));
    chk("t1.inst_data_ok_cnt", 128'(c_dok[0][0]), 128'(1));
    chk("t1.inst_rdata", 128'(l_rdata[0][0]), 128'(32'h3C1D0001));
    chk("t1.data_ok_cnt", 128'(c_aok[0][1] + c_dok[0][1]), 128'(0));

    // T2: conflict under data priority, fetch follows back-to-back
    do_reset();
    mode = 0; aok_dly = 0; dok_dly = 0; mem_word = 32'h12345678;
    q[0][0].push_back(mk(1'b0, 2'd2, 32'hBFC00004, 32'h0));
    q[0][1].push_back(mk(1'b0, 2'd2, 32'h00001000, 32'h0));
    run(8);
    chk("t2.grant_order", log_code(0), 128'(16'h21));
    chk("t2.data_ok_cnts", 128'({c_dok[0][1], c_dok[0][0]}), 128'({32'd1, 32'd1}));

    // T3: round-robin instance with both channels busy for four transactions
    do_reset();
    mode = 0; aok_dly = 0; dok_dly = 1; mem_word = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      q[1][0].push_back(mk(1'b0, 2'd2, 32'hBFC00000 + 32'(4 * i), 32'h0));
      q[1][1].push_back(mk(1'b1, 2'd2, 32'h00002000 + 32'(4 * i), 32'(i + 7)));
    end
    run(14);
    chk("t3.grant_order", log_code(1), 128'(16'h2121));
    chk("t3.prio_inst_idle", 128'(c_mreq[0]), 128'(0));

    // T4: half-word store with a slow address handshake
    do_reset();
    mode = 0; aok_dly = 3; dok_dly = 1; mem_word = 32'h0;
    q[0][1].push_back(mk(1'b1, 2'd1, 32'h00002002, 32'h0000ABCD));
    run(10);
    chk("t4.mem_req_cycles", 128'(c_mreq[0]), 128'(4));
    chk("t4.data_ok_cnts", 128'({c_aok[0][1], c_dok[0][1]}), 128'({32'd1, 32'd1}));
    chk("t4.inst_quiet", 128'(c_aok[0][0] + c_dok[0][0]), 128'(0));

    // T5: reset while waiting for data, then a stale data_ok
    do_reset();
    mode = 0; aok_dly = 0; dok_dly = 10; mem_word = 32'h55AA55AA;
    q[0][1].push_back(mk(1'b0, 2'd2, 32'h00003000, 32'h0));
    run(3);
    mode = 1; m_aok[0] = 0; m_dok[0] = 0; wait_d[0] = 0; acnt[0] = 0;
    resetn = 1'b0;
    run(1);
    resetn = 1'b1;
    clear_tally();
    m_dok[0] = 1'b1;
    #1;
    chk_outs_zero("t5.after_reset");
    run(2);
    m_dok[0] = 1'b0;
    chk("t5.stale_data_ok", 128'(c_dok[0][1] + c_dok[0][0]), 128'(0));
    mode = 0; dok_dly = 0; mem_word = 32'h0BADBEEF;
    q[0][0].push_back(mk(1'b0, 2'd2, 32'hBFC00010, 32'h0));
    run(5);
    chk("t5.next_fetch", 128'({c_dok[0][0], l_rdata[0][0]}), 128'({32'd1, 32'h0BADBEEF}));

    // T6: out-of-phase strobes are ignored
    do_reset();
    m_dok[0] = 1'b1; m_rdata[0] = 32'h11112222;
    run(2);
    m_dok[0] = 1'b0;
    q[0][0].push_back(mk(1'b0, 2'd0, 32'hBFC00020, 32'h0));
    m_aok[0] = 1'b1;
    run(2);
    run(2);
    m_aok[0] = 1'b0; m_dok[0] = 1'b1;
    run(1);
    m_dok[0] = 1'b0;
    run(2);
    chk("t6.inst_cnts", 128'({c_aok[0][0], c_dok[0][0]}), 128'({32'd1, 32'd1}));
    chk("t6.data_quiet", 128'(c_aok[0][1] + c_dok[0][1]), 128'(0));

    // Random traffic with random memory strobes and occasional resets
    do_reset();
    mode = 2; rnd_req = 1;
    repeat (3000) begin
      resetn = ($urandom_range(0, 699) != 0);
      run(1);
    end
    resetn = 1'b1;
    rnd_req = 0;
    for (int k = 0; k < 2; k++)
      chk($sformatf("rand.d%0d.both_served", k),
          128'((c_dok[k][0] > 0) && (c_dok[k][1] > 0)), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
